// File: rtl/display_buffer_pkg.sv
// Shared constants for the display-buffer PIO writer: ctrl field positions,
// status bit positions and the writer state enum.
package display_buffer_pkg;

  localparam int unsigned CTRL_WR       = 0;
  localparam int unsigned CTRL_AUTOINC  = 1;
  localparam int unsigned CTRL_PTR      = 2;
  localparam int unsigned CTRL_CHSEL_LO = 3;
  localparam int unsigned CTRL_CHSEL_HI = 4;
  localparam int unsigned CTRL_BCAST    = 5;
  localparam int unsigned CTRL_CLR      = 6;
  localparam int unsigned CTRL_SWAP     = 7;

  localparam int unsigned STAT_BUSY     = 7;
  localparam int unsigned STAT_SWAP_PND = 6;
  localparam int unsigned STAT_DROPPED  = 5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/display_buffer_writer_ctrl_toggle_detect.sv
// Turns the level-style PIO ctrl export into one-cycle toggle events.
// The first cycle after reset only captures the current ctrl value.
module ctrl_toggle_detect (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] ctrl_i,
  output logic [7:0] event_o
);

  logic [7:0] prev_q;
  logic       armed_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= 8'h00;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= ctrl_i;
      armed_q <= 1'b1;
    end
  end

  assign event_o = armed_q ? (ctrl_i ^ prev_q) : 8'h00;

endmodule

// File: rtl/display_buffer_writer.sv
// Decodes display_buffer PIO addr/data/ctrl into registered write cycles on CH
// double-banked tile RAMs, with auto-increment, broadcast, back-bank clear and frame-synced swap.
module display_buffer_writer
  import display_buffer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CH     = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] pio_addr,
  input  logic [DATA_W-1:0] pio_data,
  input  logic [7:0]        pio_ctrl,
  input  logic              frame_done,
  output logic [CH-1:0]     ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              front_bank,
  output logic              busy,
  output logic [7:0]        status
);

  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [7:0] ev;
  logic       wr_ev, ptr_ev, clr_ev, swap_ev;
  logic       autoinc, bcast, ch_ok;
  logic [1:0] ch_sel;
  logic [CH_W-1:0] ch_idx;
  logic [CH-1:0]   sel_mask;
  logic [ADDR_W-1:0] wr_addr;
  logic unused_ev;

  state_e            state_q, state_d;
  logic [CH-1:0]     ram_we_q, ram_we_d;
  logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              front_q, front_d;
  logic              swap_pnd_q, swap_pnd_d;
  logic              dropped_q, dropped_d;

  ctrl_toggle_detect u_tgl (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .ctrl_i  (pio_ctrl),
    .event_o (ev)
  );

  assign wr_ev     = ev[CTRL_WR];
  assign ptr_ev    = ev[CTRL_PTR];
  assign clr_ev    = ev[CTRL_CLR];
  assign swap_ev   = ev[CTRL_SWAP];
  assign unused_ev = ^{ev[CTRL_AUTOINC], ev[CTRL_BCAST], ev[CTRL_CHSEL_HI:CTRL_CHSEL_LO]};

  assign autoinc = pio_ctrl[CTRL_AUTOINC];
  assign bcast   = pio_ctrl[CTRL_BCAST];
  assign ch_sel  = pio_ctrl[CTRL_CHSEL_HI:CTRL_CHSEL_LO];
  assign ch_idx  = ch_sel[CH_W-1:0];
  assign ch_ok   = bcast || (int'(ch_sel) < CH);
  // A same-cycle pointer load redirects the auto-increment write to pio_addr.
  assign wr_addr = ptr_ev ? pio_addr : ptr_q;

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < CH; i++) begin
      sel_mask[i] = bcast || (ch_idx == CH_W'(i));
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_ev) state_d = S_CLEAR;
      S_CLEAR: if (clr_addr_q == ADDR_MAX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_we_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ptr_d       = ptr_q;
    clr_addr_d  = clr_addr_q;
    front_d     = front_q;
    swap_pnd_d  = swap_pnd_q;
    dropped_d   = dropped_q;

    if (ptr_ev) begin
      ptr_d     = pio_addr;
      dropped_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (clr_ev) begin
          ram_we_d    = '1;
          ram_addr_d  = {~front_q, {ADDR_W{1'b0}}};
          ram_wdata_d = '0;
          clr_addr_d  = '0;
          if (wr_ev) dropped_d = 1'b1;
        end else if (wr_ev) begin
          if (ch_ok) begin
            ram_we_d    = sel_mask;
            ram_addr_d  = {~front_q, (autoinc ? wr_addr : pio_addr)};
            ram_wdata_d = pio_data;
            if (autoinc) ptr_d = wr_addr + 1'b1;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (wr_ev || clr_ev) dropped_d = 1'b1;
        // Keep the bank chosen at clear start so the sweep never splits across banks.
        if (clr_addr_q != ADDR_MAX) begin
          ram_we_d    = '1;
          ram_addr_d  = {ram_addr_q[ADDR_W], clr_addr_q + 1'b1};
          ram_wdata_d = '0;
          clr_addr_d  = clr_addr_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (swap_ev) swap_pnd_d = 1'b1;
    if (frame_done && swap_pnd_q && (state_q == S_IDLE)) begin
      front_d    = ~front_q;
      swap_pnd_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ptr_q       <= '0;
      clr_addr_q  <= '0;
      front_q     <= 1'b0;
      swap_pnd_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ptr_q       <= ptr_d;
      clr_addr_q  <= clr_addr_d;
      front_q     <= front_d;
      swap_pnd_q  <= swap_pnd_d;
      dropped_q   <= dropped_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign front_bank = front_q;
  assign busy       = (state_q == S_CLEAR);
  assign status     = {busy, swap_pnd_q, dropped_q, 5'b0};

endmodule

// File: tb/tb_display_buffer_writer.sv
// Scoreboard bench: two instances (CH=4 and CH=3); expected RAM writes are queued
// by the stimulus and popped by a negedge monitor whenever ram_we is non-zero.
module tb_display_buffer_writer;

  localparam logic [7:0] T_WR = 8'h01, T_PTR = 8'h04, T_CLR = 8'h40, T_SWAP = 8'h80;

  typedef struct {
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] pio_addr = '0, p3_addr = '0;
  logic [31:0] pio_data = '0, p3_data = '0;
  logic [7:0]  pio_ctrl = 8'hFF, p3_ctrl = 8'hFF;
  logic        frame_done = 1'b0, p3_frame = 1'b0;

  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        front_bank, busy;
  logic [7:0]  status;
  logic [2:0]  we3;
  logic [11:0] addr3;
  logic [31:0] wdata3;
  logic        front3, busy3;
  logic [7:0]  status3;

  display_buffer_writer #(.ADDR_W(11), .DATA_W(32), .CH(4)) dut (
    .clk_clk(clk), .reset_reset(rst), .pio_addr(pio_addr), .pio_data(pio_data),
    .pio_ctrl(pio_ctrl), .frame_done(frame_done), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .front_bank(front_bank), .busy(busy), .status(status)
  );

  display_buffer_writer #(.ADDR_W(11), .DATA_W(32), .CH(3)) dut3 (
    .clk_clk(clk), .reset_reset(rst), .pio_addr(p3_addr), .pio_data(p3_data),
    .pio_ctrl(p3_ctrl), .frame_done(p3_frame), .ram_we(we3), .ram_addr(addr3),
    .ram_wdata(wdata3), .front_bank(front3), .busy(busy3), .status(status3)
  );

  int n_checks = 0, n_pass = 0, busy_cnt = 0;
  wr_t q0[$], q3[$];
  logic [7:0] tg0 = 8'hFF, tg3 = 8'hFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input bit d3, input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
    wr_t e;
    e.we = we; e.addr = a; e.data = d;
    if (d3) q3.push_back(e);
    else    q0.push_back(e);
  endtask

  // Flip the requested toggle bits, set the level fields, then let one edge pass.
  task automatic cmd(input bit d3, input logic [7:0] tmask, input logic [1:0] chsel,
                     input logic ai, input logic bc, input logic [10:0] a, input logic [31:0] d);
    if (!d3) begin
      tg0 ^= tmask;
      pio_ctrl = (tg0 & 8'hC5) | {2'b00, bc, chsel, 1'b0, ai, 1'b0};
      pio_addr = a; pio_data = d;
    end else begin
      tg3 ^= tmask;
      p3_ctrl = (tg3 & 8'hC5) | {2'b00, bc, chsel, 1'b0, ai, 1'b0};
      p3_addr = a; p3_data = d;
    end
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt += int'(busy);
      if (ram_we != 4'h0) begin
        if (q0.size() == 0) begin
          n_checks++;
          $display("FAIL wr0_unexpected: got we=%h addr=%h expected no write", ram_we, ram_addr);
        end else begin
          wr_t e;
          e = q0.pop_front();
          chk("wr0_we", 64'(ram_we), 64'(e.we));
          chk("wr0_addr", 64'(ram_addr), 64'(e.addr));
          chk("wr0_data", 64'(ram_wdata), 64'(e.data));
        end
      end
      if (we3 != 3'h0) begin
        if (q3.size() == 0) begin
          n_checks++;
          $display("FAIL wr3_unexpected: got we=%h addr=%h expected no write", we3, addr3);
        end else begin
          wr_t e;
          e = q3.pop_front();
          chk("wr3_we", 64'(we3), 64'(e.we));
          chk("wr3_addr", 64'(addr3), 64'(e.addr));
          chk("wr3_data", 64'(wdata3), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b0;
    // Reset with all ctrl bits high: nothing may be decoded as a command.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_addr", 64'(ram_addr), 64'h0);
    chk("rst_wdata", 64'(ram_wdata), 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_status", 64'(status), 64'h0);
      chk("rst_front", 64'(front_bank), 64'h0);
      tick();
    end

    // Single write to channel 2, back bank = 1.
    push(0, 4'b0100, 12'h805, 32'hDEADBEEF);
    cmd(0, T_WR, 2'd2, 1'b0, 1'b0, 11'h005, 32'hDEADBEEF);
    tick();

    // Pointer load then auto-increment across the wrap.
    cmd(0, T_PTR, 2'd0, 1'b0, 1'b0, 11'h7FE, 32'h0);
    push(0, 4'b0001, 12'hFFE, 32'h1);
    cmd(0, T_WR, 2'd0, 1'b1, 1'b0, 11'h123, 32'h1);
    push(0, 4'b0001, 12'hFFF, 32'h2);
    cmd(0, T_WR, 2'd0, 1'b1, 1'b0, 11'h123, 32'h2);
    push(0, 4'b0001, 12'h800, 32'h3);
    cmd(0, T_WR, 2'd0, 1'b1, 1'b0, 11'h123, 32'h3);
    push(0, 4'b0010, 12'h801, 32'h4);
    cmd(0, T_WR, 2'd1, 1'b1, 1'b0, 11'h123, 32'h4);
    // Pointer load and write together: write at pio_addr, pointer follows it.
    push(0, 4'b0001, 12'h810, 32'h5);
    cmd(0, T_WR | T_PTR, 2'd0, 1'b1, 1'b0, 11'h010, 32'h5);
    push(0, 4'b1111, 12'h811, 32'h6);
    cmd(0, T_WR, 2'd0, 1'b1, 1'b1, 11'h3AA, 32'h6);
    chk("status_idle", 64'(status), 64'h0);

    // Back-bank clear with a dropped write, pending swap and deferred frame_done.
    for (int k = 0; k < 2048; k++) push(0, 4'hF, 12'h800 + 12'(k), 32'h0);
    b0 = busy_cnt;
    cmd(0, T_CLR, 2'd0, 1'b0, 1'b0, 11'h0, 32'h0);
    chk("clr_busy", 64'(busy), 64'h1);
    chk("clr_status", 64'(status), 64'h80);
    repeat (5) tick();
    cmd(0, T_WR, 2'd1, 1'b0, 1'b0, 11'h055, 32'h55);
    chk("clr_wr_dropped", 64'(status[5]), 64'h1);
    cmd(0, T_SWAP, 2'd0, 1'b0, 1'b0, 11'h0, 32'h0);
    chk("swap_pending", 64'(status[6]), 64'h1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("swap_deferred_front", 64'(front_bank), 64'h0);
    chk("swap_deferred_pend", 64'(status[6]), 64'h1);
    cmd(0, T_PTR, 2'd0, 1'b0, 1'b0, 11'h000, 32'h0);
    chk("ptr_clears_dropped", 64'(status[5]), 64'h0);
    for (int i = 0; i < 3000 && busy; i++) tick();
    chk("clr_done", 64'(busy), 64'h0);
    chk("clr_busy_cycles", 64'(busy_cnt - b0), 64'd2048);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("swap_front", 64'(front_bank), 64'h1);
    chk("swap_pend_clr", 64'(status[6]), 64'h0);

    // Writes now target bank 0.
    push(0, 4'b1000, 12'h00A, 32'hA5A5A5A5);
    cmd(0, T_WR, 2'd3, 1'b0, 1'b0, 11'h00A, 32'hA5A5A5A5);

    // WR and CLR together in IDLE: clear wins, write dropped.
    for (int k = 0; k < 2048; k++) push(0, 4'hF, 12'h000 + 12'(k), 32'h0);
    cmd(0, T_WR | T_CLR, 2'd1, 1'b0, 1'b0, 11'h077, 32'h77);
    chk("wrclr_busy", 64'(busy), 64'h1);
    chk("wrclr_dropped", 64'(status[5]), 64'h1);
    for (int i = 0; i < 3000 && busy; i++) tick();
    chk("wrclr_done", 64'(busy), 64'h0);

    // Write in the swap cycle still uses the pre-swap back bank.
    cmd(0, T_SWAP | T_PTR, 2'd0, 1'b0, 1'b0, 11'h000, 32'h0);
    push(0, 4'b0001, 12'h020, 32'hC0FFEE00);
    frame_done = 1'b1;
    cmd(0, T_WR, 2'd0, 1'b0, 1'b0, 11'h020, 32'hC0FFEE00);
    frame_done = 1'b0;
    chk("swapcyc_front", 64'(front_bank), 64'h0);
    chk("swapcyc_status", 64'(status), 64'h0);

    // CH=3: out-of-range channel dropped unless broadcast.
    cmd(1, T_WR, 2'd3, 1'b0, 1'b0, 11'h044, 32'h66);
    chk("ch3_dropped", 64'(status3), 64'h20);
    push(1, 4'b0111, 12'h844, 32'h77);
    cmd(1, T_WR, 2'd3, 1'b0, 1'b1, 11'h044, 32'h77);
    push(1, 4'b0100, 12'h845, 32'h88);
    cmd(1, T_WR, 2'd2, 1'b0, 1'b0, 11'h045, 32'h88);
    repeat (3) tick();

    chk("q0_drained", 64'(q0.size()), 64'h0);
    chk("q3_drained", 64'(q3.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
